// File: rtl/fc_pkg.sv
// Shared types and helpers for the FC1 accumulator stage: FSM encoding,
// the IEEE-754 zero constant and the lane slicing helper.
package fc_pkg;

    localparam int          DATA_WIDTH_DEF = 32;
    localparam logic [31:0] FP_ZERO        = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        BIAS,
        DONE
    } state_t;

    function automatic int laneLsb(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/FP_Adder.sv
// Combinational IEEE-754 single-precision adder, round-to-nearest-even,
// gradual underflow supported, no exception flags.
module FP_Adder (
    input  logic [31:0] FP_in1,
    input  logic [31:0] FP_in2,
    output logic [31:0] FP_out
);

    logic        w_swap;
    logic [31:0] w_big;
    logic [31:0] w_small;
    logic [7:0]  w_expBig;
    logic [7:0]  w_expSmall;
    logic [7:0]  w_shift;
    logic [26:0] w_manBig;
    logic [26:0] w_manSmall;
    logic [26:0] w_aligned;
    logic [27:0] w_sum;
    logic [4:0]  w_lz;
    logic [7:0]  w_lshift;
    logic [26:0] w_norm;
    logic [9:0]  w_exp;
    logic        w_roundUp;
    logic [24:0] w_rounded;
    logic [9:0]  w_expOut;
    logic [22:0] w_frac;
    logic        w_sign;

    // Mantissas carry three extra bits (guard, round, sticky) so the final
    // rounding sees everything that was shifted out during alignment.
    always_comb begin
        w_swap     = FP_in2[30:0] > FP_in1[30:0];
        w_big      = w_swap ? FP_in2 : FP_in1;
        w_small    = w_swap ? FP_in1 : FP_in2;
        w_expBig   = (w_big[30:23] == 8'd0) ? 8'd1 : w_big[30:23];
        w_expSmall = (w_small[30:23] == 8'd0) ? 8'd1 : w_small[30:23];
        w_manBig   = {(w_big[30:23] != 8'd0), w_big[22:0], 3'b000};
        w_manSmall = {(w_small[30:23] != 8'd0), w_small[22:0], 3'b000};
        w_shift    = w_expBig - w_expSmall;
        w_aligned  = '0;
        w_lz       = '0;
        w_lshift   = '0;
        w_norm     = '0;
        w_exp      = {2'b00, w_expBig};

        if (w_shift > 8'd26) begin
            w_aligned = {26'd0, |w_manSmall};
        end else begin
            w_aligned    = w_manSmall >> w_shift;
            w_aligned[0] = w_aligned[0] | (|(w_manSmall & ~({27{1'b1}} << w_shift)));
        end

        if (w_big[31] == w_small[31]) begin
            w_sum = {1'b0, w_manBig} + {1'b0, w_aligned};
        end else begin
            w_sum = {1'b0, w_manBig} - {1'b0, w_aligned};
        end

        if (w_sum[27]) begin
            w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
            w_exp  = w_exp + 10'd1;
        end else begin
            w_lz = 5'd27;
            for (int i = 0; i <= 26; i++) begin
                if (w_sum[i]) w_lz = 5'(26 - i);
            end
            // Never normalise below the minimum exponent; the result becomes subnormal.
            if ({3'b000, w_lz} >= w_expBig) w_lshift = w_expBig - 8'd1;
            else                            w_lshift = {3'b000, w_lz};
            w_norm = w_sum[26:0] << w_lshift;
            w_exp  = w_exp - {2'b00, w_lshift};
        end

        w_roundUp = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
        w_rounded = {1'b0, w_norm[26:3]} + {24'd0, w_roundUp};

        if (w_rounded[24]) begin
            w_expOut = w_exp + 10'd1;
            w_frac   = w_rounded[23:1];
        end else begin
            w_expOut = w_rounded[23] ? w_exp : 10'd0;
            w_frac   = w_rounded[22:0];
        end

        w_sign = (w_sum == 28'd0 && w_big[31] != w_small[31]) ? 1'b0 : w_big[31];

        if (w_sum == 28'd0)            FP_out = {w_sign, 31'd0};
        else if (w_expOut >= 10'd255)  FP_out = {w_sign, 8'hFF, 23'd0};
        else                           FP_out = {w_sign, w_expOut[7:0], w_frac};

        if (FP_in1[30:23] == 8'hFF && FP_in2[30:23] == 8'hFF && FP_in1[22:0] == 23'd0 &&
            FP_in2[22:0] == 23'd0 && FP_in1[31] != FP_in2[31]) begin
            FP_out = 32'h7FC0_0000;
        end else if (FP_in1[30:23] == 8'hFF) begin
            FP_out = FP_in1;
        end else if (FP_in2[30:23] == 8'hFF) begin
            FP_out = FP_in2;
        end
    end

endmodule

// File: rtl/fc_acc_lane.sv
// One neuron lane: running FP accumulator, shared adder for products and
// bias, and the registered ReLU result.
module fc_acc_lane
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter bit RELU_EN    = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_clear,
    input  logic                  i_load,
    input  logic                  i_biasSel,
    input  logic [DATA_WIDTH-1:0] i_prod,
    input  logic [DATA_WIDTH-1:0] i_bias,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0] r_acc;
    logic [DATA_WIDTH-1:0] r_result;
    logic [DATA_WIDTH-1:0] w_operand;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_relu;

    assign w_operand = i_biasSel ? i_bias : i_prod;
    assign w_relu    = (RELU_EN && w_sum[DATA_WIDTH-1]) ? FP_ZERO : w_sum;
    assign o_result  = r_result;

    FP_Adder u_adder (
        .FP_in1 (r_acc),
        .FP_in2 (w_operand),
        .FP_out (w_sum)
    );

    // The bias cycle reuses the accumulator's adder and lands in the result register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_acc    <= FP_ZERO;
            r_result <= FP_ZERO;
        end else if (i_clear) begin
            r_acc <= FP_ZERO;
        end else if (i_load) begin
            if (i_biasSel) r_result <= w_relu;
            else           r_acc    <= w_sum;
        end
    end

endmodule

// File: rtl/fc_accumulator.sv
// FC1 output stage: accumulates IFM_DEPTH product beats per neuron, adds bias,
// applies optional ReLU and hands one packed result vector to FC2.
module fc_accumulator
    import fc_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int IFM_DEPTH   = 120,
    parameter int NUM_NEURONS = 84,
    parameter bit RELU_EN     = 1'b1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] prod_in,
    input  logic                              prod_valid,
    output logic                              prod_ready,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] bias_in,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              busy
);

    localparam int CNT_W = (IFM_DEPTH > 1) ? $clog2(IFM_DEPTH) : 1;

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;
    logic             w_lastBeat;
    logic             w_clear;
    logic             w_load;
    logic             w_biasSel;

    assign w_accept   = prod_valid && (r_state == ACCUM);
    assign w_lastBeat = w_accept && (r_cnt == CNT_W'(IFM_DEPTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start)      w_nextState = ACCUM;
            ACCUM:   if (w_lastBeat) w_nextState = BIAS;
            BIAS:                    w_nextState = DONE;
            DONE:    if (out_ready)  w_nextState = IDLE;
            default:                 w_nextState = IDLE;
        endcase
    end

    always_comb begin
        prod_ready = (r_state == ACCUM);
        out_valid  = (r_state == DONE);
        busy       = (r_state != IDLE);
        w_clear    = (r_state == IDLE) && start;
        w_load     = w_accept || (r_state == BIAS);
        w_biasSel  = (r_state == BIAS);
    end

    // Counter returns to zero on the last beat so it never wraps.
    always_ff @(posedge clk) begin
        if (!rst_n)          r_cnt <= '0;
        else if (w_clear)    r_cnt <= '0;
        else if (w_lastBeat) r_cnt <= '0;
        else if (w_accept)   r_cnt <= r_cnt + CNT_W'(1);
    end

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_lane
        fc_acc_lane #(
            .DATA_WIDTH (DATA_WIDTH),
            .RELU_EN    (RELU_EN)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_clear   (w_clear),
            .i_load    (w_load),
            .i_biasSel (w_biasSel),
            .i_prod    (prod_in[laneLsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .i_bias    (bias_in[laneLsb(g, DATA_WIDTH) +: DATA_WIDTH]),
            .o_result  (out_data[laneLsb(g, DATA_WIDTH) +: DATA_WIDTH])
        );
    end

endmodule
